// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C configuration sequencer.
//   op_e    : 2-bit opcode held in the top bits of every ROM word
//   state_e : sequencer FSM states
//   OpW/ArgW: header field widths; the header occupies the top HdrW bits of a ROM word
package i2c_seq_pkg;

  localparam int unsigned OpW  = 2;
  localparam int unsigned ArgW = 6;
  localparam int unsigned HdrW = OpW + ArgW;

  typedef enum logic [OpW-1:0] {
    OP_END   = 2'b00,
    OP_WRITE = 2'b01,
    OP_DELAY = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StSend,
    StWait,
    StDelay,
    StNext,
    StDone,
    StError
  } state_e;

  // $clog2 that never returns 0, for sizing vectors that must exist even when degenerate.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter used by the DELAY command.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   load_i         : load load_val_i (takes priority over dec_i)
//   load_val_i     : value to load
//   dec_i          : decrement by one; saturates at zero
//   zero_o         : counter currently holds zero
module i2c_seq_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_seq_controller.sv
// Command-driven I2C configuration sequencer. Walks opcode words from an external synchronous
// ROM (one-cycle read latency) and drives a byte-level I2C engine.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   start_1cc_i, seq_sel_i  : start pulse and sequence index (accepted in IDLE/DONE/ERROR)
//   busy_o, done_o, error_o : status; done/error are sticky until the next accepted start
//   err_addr_o              : ROM address of the failing command
//   rom_addr_o, rom_data_i  : ROM read port
//   eng_*                   : engine handshake; nbytes/data held from send until done
module i2c_seq_controller
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NBYTES     = 3,
  parameter int unsigned SEQ_AW     = 6,
  parameter int unsigned NSEQ       = 2,
  parameter int unsigned DELAY_UNIT = 1000,
  parameter int unsigned MAX_RETRY  = 3,
  localparam int unsigned DW   = 8 * NBYTES + 8,
  localparam int unsigned SelW = clog2_min1(NSEQ),
  localparam int unsigned AwRaw = SEQ_AW + ((NSEQ > 1) ? $clog2(NSEQ) : 0),
  localparam int unsigned AW   = (AwRaw >= 1) ? AwRaw : 1,
  localparam int unsigned NbW  = clog2_min1(NBYTES + 1),
  localparam int unsigned PW   = 8 * NBYTES
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_1cc_i,
  input  logic [SelW-1:0] seq_sel_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [AW-1:0]   err_addr_o,
  output logic [AW-1:0]   rom_addr_o,
  input  logic [DW-1:0]   rom_data_i,
  output logic            eng_send_o,
  output logic [NbW-1:0]  eng_nbytes_o,
  output logic [PW-1:0]   eng_data_o,
  input  logic            eng_done_i,
  input  logic            eng_nack_i,
  input  logic            eng_ready_i
);

  localparam int unsigned RtW = clog2_min1(MAX_RETRY + 1);
  // Sized for the largest argument so arg*DELAY_UNIT-1 can never overflow.
  localparam int unsigned TW  = clog2_min1(63 * DELAY_UNIT + 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;
  logic [RtW-1:0]   retry_q, retry_d;
  logic [NbW-1:0]   nbytes_q, nbytes_d;
  logic [PW-1:0]    data_q, data_d;

  op_e              op;
  logic [ArgW-1:0]  arg;
  logic             write_ok;
  logic             last_in_window;
  logic             timer_load, timer_dec, timer_zero;
  logic [TW-1:0]    timer_load_val;

  assign op  = op_e'(rom_data_i[DW-1 -: OpW]);
  assign arg = rom_data_i[DW-OpW-1 -: ArgW];

  assign write_ok       = (arg != '0) && (32'(arg) <= NBYTES);
  assign timer_load_val = TW'(arg) * TW'(DELAY_UNIT) - TW'(1);
  // Sequences must terminate inside their own window; running off the end is an error.
  assign last_in_window = &addr_q[SEQ_AW-1:0];

  i2c_seq_timer #(
    .Width (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    retry_d    = retry_q;
    nbytes_d   = nbytes_q;
    data_d     = data_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    eng_send_o = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_1cc_i) begin
          state_d = StFetch;
          addr_d  = AW'({seq_sel_i, {SEQ_AW{1'b0}}});
          retry_d = '0;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (op)
          OP_END: state_d = StDone;
          OP_WRITE: begin
            if (write_ok) begin
              nbytes_d = NbW'(arg);
              data_d   = rom_data_i[PW-1:0];
              state_d  = StSend;
            end else begin
              err_addr_d = addr_q;
              state_d    = StError;
            end
          end
          OP_DELAY: begin
            if (arg == '0) begin
              state_d = StNext;
            end else begin
              timer_load = 1'b1;
              state_d    = StDelay;
            end
          end
          OP_ILL: begin
            err_addr_d = addr_q;
            state_d    = StError;
          end
          default: state_d = StError;
        endcase
      end
      StSend: begin
        if (eng_ready_i) begin
          eng_send_o = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (eng_done_i) begin
          if (!eng_nack_i) begin
            retry_d = '0;
            state_d = StNext;
          end else if (retry_q < RtW'(MAX_RETRY)) begin
            retry_d = retry_q + RtW'(1);
            state_d = StSend;
          end else begin
            err_addr_d = addr_q;
            state_d    = StError;
          end
        end
      end
      StDelay: begin
        if (timer_zero) begin
          state_d = StNext;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StNext: begin
        if (last_in_window) begin
          err_addr_d = addr_q;
          state_d    = StError;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      err_addr_q <= '0;
      retry_q    <= '0;
      nbytes_q   <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      retry_q    <= retry_d;
      nbytes_q   <= nbytes_d;
      data_q     <= data_d;
    end
  end

  assign busy_o       = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
  assign done_o       = (state_q == StDone);
  assign error_o      = (state_q == StError);
  assign err_addr_o   = err_addr_q;
  assign rom_addr_o   = addr_q;
  assign eng_nbytes_o = nbytes_q;
  assign eng_data_o   = data_q;

endmodule

// File: tb/tb_i2c_seq_controller.sv
module tb_i2c_seq_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [0:0]  seq_sel;
  logic        busy, done, error;
  logic [6:0]  err_addr, rom_addr;
  logic [31:0] rom_data;
  logic        eng_send;
  logic [1:0]  eng_nbytes;
  logic [23:0] eng_data;
  logic        eng_done, eng_nack, eng_ready;

  logic [31:0] rom [128];
  logic        ready_en;
  logic [2:0]  pend_q;
  int          send_cnt;
  int          cur_idx;
  int          nack_until;
  logic [1:0]  log_nb [64];
  logic [23:0] log_data [64];

  int n_run  = 0;
  int n_fail = 0;
  int base;
  int k;

  i2c_seq_controller #(
    .DELAY_UNIT (10)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_1cc_i  (start),
    .seq_sel_i    (seq_sel),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .err_addr_o   (err_addr),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .eng_send_o   (eng_send),
    .eng_nbytes_o (eng_nbytes),
    .eng_data_o   (eng_data),
    .eng_done_i   (eng_done),
    .eng_nack_i   (eng_nack),
    .eng_ready_i  (eng_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Engine model: done pulse 4 cycles after send; NACKs every send whose index < nack_until.
  assign eng_ready = ready_en && (pend_q == 3'd0);
  always @(posedge clk) begin
    eng_done <= 1'b0;
    eng_nack <= 1'b0;
    if (!rst_n) begin
      pend_q   <= 3'd0;
      send_cnt <= 0;
      cur_idx  <= 0;
    end else if (eng_send) begin
      pend_q                   <= 3'd3;
      cur_idx                  <= send_cnt;
      log_nb[send_cnt[5:0]]    <= eng_nbytes;
      log_data[send_cnt[5:0]]  <= eng_data;
      send_cnt                 <= send_cnt + 1;
    end else if (pend_q != 3'd0) begin
      pend_q <= pend_q - 3'd1;
      if (pend_q == 3'd1) begin
        eng_done <= 1'b1;
        eng_nack <= (cur_idx < nack_until);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic s);
    start   = 1'b1;
    seq_sel = s;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_send(input int budget, input string tag);
    int i = 0;
    while (!eng_send && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_send_timeout"}, {31'd0, eng_send}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    seq_sel    = 1'b0;
    ready_en   = 1'b1;
    nack_until = 0;
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;

    // Reset state
    tick(); tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_send", {31'd0, eng_send}, 32'd0);
    check("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    check("rst_err_addr", {25'd0, err_addr}, 32'd0);
    check("rst_nbytes", {30'd0, eng_nbytes}, 32'd0);
    check("rst_data", {8'd0, eng_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: two WRITEs then END, all acked
    rom[0] = 32'h4272_0800;
    rom[1] = 32'h4372_4110;
    rom[2] = 32'h0000_0000;
    base = send_cnt;
    pulse_start(1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_fetch_nosend", {31'd0, eng_send}, 32'd0);
    tick(); tick();
    check("t1_latency_send", {31'd0, eng_send}, 32'd1);
    check("t1_nbytes0", {30'd0, eng_nbytes}, 32'd2);
    check("t1_data0", {8'd0, eng_data}, 32'h72_0800);
    wait_idle(200, "t1");
    check("t1_sends", send_cnt - base, 32'd2);
    check("t1_log_nb1", {30'd0, log_nb[base+1]}, 32'd3);
    check("t1_log_data1", {8'd0, log_data[base+1]}, 32'h72_4110);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);

    // 2: NACK twice then ack -> three identical sends
    rom[0] = 32'h8000_0000;
    rom[1] = 32'h42AB_CD00;
    rom[2] = 32'h0000_0000;
    base = send_cnt;
    nack_until = base + 2;
    pulse_start(1'b0);
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    wait_idle(300, "t2");
    check("t2_sends", send_cnt - base, 32'd3);
    check("t2_data_first", {8'd0, log_data[base]}, 32'hAB_CD00);
    check("t2_data_last", {8'd0, log_data[base+2]}, 32'hAB_CD00);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_error", {31'd0, error}, 32'd0);

    // 3: NACK four times -> error at addr 1; start during WAIT ignored
    base = send_cnt;
    nack_until = base + 4;
    pulse_start(1'b0);
    wait_send(50, "t3");
    tick();
    pulse_start(1'b1);
    check("t3_start_ignored_addr", {25'd0, rom_addr}, 32'd1);
    check("t3_start_ignored_busy", {31'd0, busy}, 32'd1);
    wait_idle(300, "t3");
    check("t3_sends", send_cnt - base, 32'd4);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_err_addr", {25'd0, err_addr}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd0);

    // 4: DELAY 2 with DELAY_UNIT=10 -> 2 + 20 + 1 cycles until addr 1 is fetched
    rom[0] = 32'h8200_0000;
    rom[1] = 32'h0000_0000;
    pulse_start(1'b0);
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    k = 0;
    while (rom_addr != 7'd1 && k < 100) begin
      tick();
      k++;
    end
    check("t4_delay_cycles", k, 32'd23);
    wait_idle(20, "t4");
    check("t4_done", {31'd0, done}, 32'd1);

    // 5: sequence 1 with no END in its window
    for (int i = 64; i < 128; i++) rom[i] = 32'h8000_0000;
    base = send_cnt;
    pulse_start(1'b1);
    check("t5_first_addr", {25'd0, rom_addr}, 32'd64);
    wait_idle(400, "t5");
    check("t5_error", {31'd0, error}, 32'd1);
    check("t5_err_addr", {25'd0, err_addr}, 32'd127);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_no_sends", send_cnt - base, 32'd0);

    // 6: illegal opcode, WRITE length 0 and > NBYTES
    rom[0] = 32'hC000_0000;
    pulse_start(1'b0);
    check("t6_error_cleared", {31'd0, error}, 32'd0);
    wait_idle(20, "t6_ill");
    check("t6_ill_error", {31'd0, error}, 32'd1);
    check("t6_ill_err_addr", {25'd0, err_addr}, 32'd0);
    rom[0] = 32'h4000_0000;
    pulse_start(1'b0);
    wait_idle(20, "t6_len0");
    check("t6_len0_error", {31'd0, error}, 32'd1);
    rom[0] = 32'h4400_0000;
    pulse_start(1'b0);
    wait_idle(20, "t6_len4");
    check("t6_len4_error", {31'd0, error}, 32'd1);

    // 6: reset mid-WAIT
    rom[0] = 32'h42AB_CD00;
    rom[1] = 32'h0000_0000;
    pulse_start(1'b0);
    wait_send(50, "t6_rst");
    tick();
    check("t6_wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_error", {31'd0, error}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_nbytes", {30'd0, eng_nbytes}, 32'd0);
    check("t6_rst_data", {8'd0, eng_data}, 32'd0);
    check("t6_rst_send", {31'd0, eng_send}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
